cp_insert: RTL

CP_INSERT -- requirements
Module: cp_insert

---
 rtl/cp_insert.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cp_insert.sv
// Cyclic-prefix inserter: ping-pong symbol banks, then each symbol is replayed as its last CP_LEN samples followed by all N samples.
// Optional SOP alignment checking and resync is enabled by defining CP_INSERT_SOP_CHECK_EN.
module cp_insert #(
  parameter int DW     = 18,
  parameter int N      = 64,
  parameter int CP_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] din_real,
  input  logic signed [DW-1:0] din_imag,
  input  logic                 din_valid,
  input  logic                 din_sop,
  output logic                 din_ready,
  output logic signed [DW-1:0] dout_real,
  output logic signed [DW-1:0] dout_imag,
  output logic                 dout_valid,
  output logic                 dout_sop,
  output logic                 dout_eop,
  output logic                 err_sop,
  output logic [1:0]           dbg_state
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] CP_START = AW'(N - CP_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CP = 2'd1, BODY = 2'd2} state_t;

  // Handshake: a sample transfers on a rising edge where din_valid and din_ready are both high;
  // din_ready depends only on registered state, and the output side has no backpressure.

  logic [DW-1:0] mem_real [2*N];
  logic [DW-1:0] mem_imag [2*N];

  logic [AW-1:0] wr_idx;
  logic          wr_bank;
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          rd_bank;
  logic          rd_bank_nxt;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] rd_idx_nxt;
  state_t        state;
  state_t        state_nxt;
  logic          rd_en;
  logic          free_bank;
  logic          accept;
  logic          wr_last;
  logic [AW-1:0] wr_addr_idx;

  assign din_ready = ~full[wr_bank];
  assign accept    = din_valid & din_ready;
  assign dbg_state = state;

`ifdef CP_INSERT_SOP_CHECK_EN
  logic sop_err_now;

  // A SOP restarts the current bank at index 0, dropping the partial symbol.
  always_comb begin
    wr_addr_idx = din_sop ? '0 : wr_idx;
    sop_err_now = accept & ((din_sop & (wr_idx != '0)) | (~din_sop & (wr_idx == '0)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sop <= 1'b0;
    end else if (sop_err_now) begin
      err_sop <= 1'b1;
    end
  end
`else
  logic unused_sop;

  assign unused_sop  = din_sop;
  assign wr_addr_idx = wr_idx;
  assign err_sop     = 1'b0;
`endif

  assign wr_last   = accept & (wr_addr_idx == LAST_IDX);
  assign free_bank = (state == BODY) & (rd_idx == LAST_IDX);

  // The write bank is never full while writing and the read bank is always full,
  // so a free and a fill in the same cycle always target different banks.
  always_comb begin
    full_nxt = full;
    if (free_bank) full_nxt[rd_bank] = 1'b0;
    if (wr_last)   full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      full <= full_nxt;
      if (accept) begin
        if (wr_last) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_addr_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_real[{wr_bank, wr_addr_idx}] <= din_real;
      mem_imag[{wr_bank, wr_addr_idx}] <= din_imag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_idx  <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_idx  <= rd_idx_nxt;
      rd_bank <= rd_bank_nxt;
    end
  end

  // CP walks the tail of the symbol; the index wraps from N-1 to 0 straight into BODY.
  always_comb begin
    state_nxt   = state;
    rd_idx_nxt  = rd_idx;
    rd_bank_nxt = rd_bank;
    rd_en       = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_nxt  = CP;
          rd_idx_nxt = CP_START;
        end
      end
      CP: begin
        rd_en      = 1'b1;
        rd_idx_nxt = rd_idx + 1'b1;
        if (rd_idx == LAST_IDX) state_nxt = BODY;
      end
      BODY: begin
        rd_en      = 1'b1;
        rd_idx_nxt = rd_idx + 1'b1;
        if (rd_idx == LAST_IDX) begin
          rd_bank_nxt = ~rd_bank;
          if (full[~rd_bank]) begin
            state_nxt  = CP;
            rd_idx_nxt = CP_START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register; data holds its last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_real  <= '0;
      dout_imag  <= '0;
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
    end else begin
      dout_valid <= rd_en;
      dout_sop   <= (state == CP) & (rd_idx == CP_START);
      dout_eop   <= free_bank;
      if (rd_en) begin
        dout_real <= mem_real[{rd_bank, rd_idx}];
        dout_imag <= mem_imag[{rd_bank, rd_idx}];
      end
    end
  end

endmodule
